ballot_unit: RTL and testbench
==============================

BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the number of clock cycles an armed ballot waits for a press before it expires (legal range 2..65535).
REQ-002 The block SHALL have parameter BALLOT_W, default 8, meaning the width of the ballot counter.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port arm  input  1  officer enable; a synchronous pulse or level that opens one ballot.
REQ-006 The block SHALL have port btn_a  input  1  candidate-A button; asynchronous to clk.
REQ-007 The block SHALL have port btn_b  input  1  candidate-B button; asynchronous to clk.
REQ-008 The block SHALL have port vote_a  output  1  single-cycle pulse, one per accepted A ballot; drives the tally counter's A increment.
REQ-009 The block SHALL have port vote_b  output  1  single-cycle pulse, one per accepted B ballot; drives the tally counter's B increment.
REQ-010 The block SHALL have port ready  output  1  high while a ballot is armed (voter lamp).
REQ-011 The block SHALL have port spoiled  output  1  single-cycle pulse when a ballot is rejected.
REQ-012 The block SHALL have port expired  output  1  single-cycle pulse when an armed ballot times out.
REQ-013 The block SHALL have port ballots_cast  output  BALLOT_W  count of accepted ballots.

Function
REQ-014 The block SHALL pass btn_a and btn_b each through a two-flop synchronizer, followed by a third register for edge detection; a press is a synchronized 0->1 transition only.
REQ-015 The block SHALL implement the FSM states IDLE, ARMED, and WAIT_REL, all with registered outputs.
REQ-016 In IDLE, the block SHALL hold ready=0, ignore button edges, and transition to ARMED on the first edge where arm=1.
REQ-017 In ARMED, the block SHALL hold ready=1; arm=1 SHALL be ignored and SHALL NOT restart the timeout.
REQ-018 In ARMED, on an A edge alone, the block SHALL pulse vote_a for exactly one cycle on the next edge, increment ballots_cast, and go to WAIT_REL.
REQ-019 In ARMED, on a B edge alone, the block SHALL behave symmetrically to REQ-018 using vote_b.
REQ-020 In ARMED, on A and B edges detected in the same cycle, the block SHALL pulse spoiled, emit no vote pulse, leave ballots_cast unchanged, and go to WAIT_REL.
REQ-021 Latency: a button SHALL produce its vote pulse in the cycle after the 4th rising clk edge that samples the button high (2 synchronizer stages + edge register + output register).
REQ-022 A button already held when ARMED is entered SHALL NOT vote; it SHALL be released and pressed again.
REQ-023 In ARMED, a 16-bit wait counter SHALL start from 0 on entry; when it reaches TIMEOUT_CYCLES-1 with no press, the block SHALL pulse expired and return to IDLE.
REQ-024 A press detected in the same cycle as the terminal count SHALL win: the vote is accepted and expired is not pulsed.
REQ-025 In WAIT_REL, the block SHALL go to IDLE once both synchronized buttons are low; a new arm SHALL NOT be honoured until IDLE is reached.
REQ-026 ballots_cast SHALL wrap from 2^BALLOT_W-1 to 0 without any flag.
REQ-027 vote_a and vote_b SHALL never be high in the same cycle, and at most one vote pulse SHALL occur per arm.

Reset
REQ-028 While reset=0, the block SHALL force state to IDLE; vote_a, vote_b, ready, spoiled, expired, ballots_cast, the wait counter, and all synchronizer/edge registers SHALL be 0.
REQ-029 Assertion of reset SHALL take effect immediately, without waiting for a clk edge.
REQ-030 Reset asserted mid-ballot SHALL discard that ballot with no pulse; after release the block SHALL start in IDLE.

Verification
REQ-031 The bench SHALL cover: arm pulse, then btn_a held 10 cycles -> ready=1, exactly one vote_a pulse 4 edges after the press, ballots_cast 0->1, ready=0.
REQ-032 The bench SHALL cover: btn_a and btn_b rising on the same clk edge while armed -> one spoiled pulse, no vote pulses, ballots_cast unchanged.
REQ-033 The bench SHALL cover: TIMEOUT_CYCLES=8, arm with no press -> expired pulses once 8 cycles after ARMED entry, then IDLE; a later btn_b press -> no vote_b.
REQ-034 The bench SHALL cover: btn_b held before arm and kept high -> no vote; then btn_b released and re-pressed -> exactly one vote_b.
REQ-035 The bench SHALL cover: 256 accepted ballots with BALLOT_W=8 -> ballots_cast returns to 0.
REQ-036 The bench SHALL cover: reset driven low between arm and press -> all outputs 0 at once; after release, a press without arm -> no vote.

Source files
------------

// File: rtl/ballot_unit.sv
// Single-ballot voting controller: synchronizes two candidate buttons, accepts
// one press per armed ballot, and flags spoiled (simultaneous) or expired ballots.
module ballot_unit #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BALLOT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                btn_a,
  input  logic                btn_b,
  output logic                vote_a,
  output logic                vote_b,
  output logic                ready,
  output logic                spoiled,
  output logic                expired,
  output logic [BALLOT_W-1:0] ballots_cast
);

  // state    | meaning
  // IDLE     | no ballot open, buttons ignored, waiting for arm
  // ARMED    | ballot open, voter lamp lit, wait counter running
  // WAIT_REL | ballot closed, waiting for both buttons to be released
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;

  // Bit 0 tracks button A, bit 1 tracks button B.
  logic [1:0] btn_s1;
  logic [1:0] btn_s2;
  logic [1:0] btn_s3;
  logic [1:0] btn_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      btn_s1       <= '0;
      btn_s2       <= '0;
      btn_s3       <= '0;
      btn_rise     <= '0;
      vote_a       <= 1'b0;
      vote_b       <= 1'b0;
      ready        <= 1'b0;
      spoiled      <= 1'b0;
      expired      <= 1'b0;
      ballots_cast <= '0;
    end else begin
      btn_s1   <= {btn_b, btn_a};
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      btn_rise <= btn_s2 & ~btn_s3;

      vote_a  <= 1'b0;
      vote_b  <= 1'b0;
      spoiled <= 1'b0;
      expired <= 1'b0;

      case (state)
        IDLE: begin
          if (arm) begin
            state    <= ARMED;
            ready    <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ARMED: begin
          // A press is checked before the terminal count so it wins a tie.
          if (btn_rise == 2'b11) begin
            spoiled <= 1'b1;
            ready   <= 1'b0;
            state   <= WAIT_REL;
          end else if (btn_rise[0]) begin
            vote_a       <= 1'b1;
            ballots_cast <= ballots_cast + 1'b1;
            ready        <= 1'b0;
            state        <= WAIT_REL;
          end else if (btn_rise[1]) begin
            vote_b       <= 1'b1;
            ballots_cast <= ballots_cast + 1'b1;
            ready        <= 1'b0;
            state        <= WAIT_REL;
          end else if (wait_cnt == WAIT_LAST) begin
            expired <= 1'b1;
            ready   <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WAIT_REL: begin
          if (btn_s2 == 2'b00) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_unit.sv
// Directed bench for ballot_unit with a short timeout so expiry is reachable.
module tb_ballot_unit;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          btn_a;
  logic          btn_b;
  logic          vote_a;
  logic          vote_b;
  logic          ready;
  logic          spoiled;
  logic          expired;
  logic [BW-1:0] ballots_cast;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt_va = 0;
  int cnt_vb = 0;
  int cnt_sp = 0;
  int cnt_ex = 0;
  int cnt_both = 0;

  int base_va, base_vb, base_sp, base_ex;

  ballot_unit #(.TIMEOUT_CYCLES(8), .BALLOT_W(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .btn_a        (btn_a),
    .btn_b        (btn_b),
    .vote_a       (vote_a),
    .vote_b       (vote_b),
    .ready        (ready),
    .spoiled      (spoiled),
    .expired      (expired),
    .ballots_cast (ballots_cast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vote_a) cnt_va++;
    if (vote_b) cnt_vb++;
    if (spoiled) cnt_sp++;
    if (expired) cnt_ex++;
    if (vote_a && vote_b) cnt_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_va = cnt_va;
    base_vb = cnt_vb;
    base_sp = cnt_sp;
    base_ex = cnt_ex;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    arm   = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    step(2);
    chk("rst_ready", ready, 0);
    chk("rst_votes", {vote_a, vote_b, spoiled, expired}, 0);
    chk("rst_count", ballots_cast, 0);
    reset = 1'b1;
    step(2);

    // Arm, then hold A for 10 cycles: vote after the 4th sampling edge.
    snap();
    arm_pulse();
    chk("t1_ready_armed", ready, 1);
    btn_a = 1'b1;
    step(3);
    chk("t1_no_vote_early", vote_a, 0);
    step(1);
    chk("t1_vote_a", vote_a, 1);
    chk("t1_count", ballots_cast, 1);
    chk("t1_ready_off", ready, 0);
    step(1);
    chk("t1_vote_a_single", vote_a, 0);
    step(5);
    btn_a = 1'b0;
    step(4);
    chk("t1_pulses_a", cnt_va - base_va, 1);
    chk("t1_pulses_b", cnt_vb - base_vb, 0);

    // Simultaneous press spoils the ballot.
    snap();
    arm_pulse();
    btn_a = 1'b1;
    btn_b = 1'b1;
    step(4);
    chk("t2_spoiled", spoiled, 1);
    chk("t2_count", ballots_cast, 1);
    step(1);
    chk("t2_spoiled_single", spoiled, 0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    step(4);
    chk("t2_votes", (cnt_va - base_va) + (cnt_vb - base_vb), 0);
    chk("t2_sp_pulses", cnt_sp - base_sp, 1);

    // No press: expired 8 edges after ARMED entry, then B is ignored.
    snap();
    arm_pulse();
    chk("t3_ready", ready, 1);
    step(7);
    chk("t3_not_yet", expired, 0);
    step(1);
    chk("t3_expired", expired, 1);
    chk("t3_ready_off", ready, 0);
    step(1);
    chk("t3_exp_single", expired, 0);
    btn_b = 1'b1;
    step(6);
    btn_b = 1'b0;
    step(3);
    chk("t3_no_vote_b", cnt_vb - base_vb, 0);
    chk("t3_ex_pulses", cnt_ex - base_ex, 1);

    // B held across arm does not vote; a re-press lands on the terminal
    // count edge and must still be accepted without an expiry.
    snap();
    btn_b = 1'b1;
    step(5);
    arm_pulse();
    step(2);
    chk("t4_held_no_vote", cnt_vb - base_vb, 0);
    chk("t4_still_ready", ready, 1);
    btn_b = 1'b0;
    step(2);
    btn_b = 1'b1;
    step(4);
    chk("t4_vote_b", vote_b, 1);
    chk("t4_no_expire", expired, 0);
    chk("t4_count", ballots_cast, 2);
    step(1);
    btn_b = 1'b0;
    step(4);
    chk("t4_pulses_b", cnt_vb - base_vb, 1);
    chk("t4_ex_pulses", cnt_ex - base_ex, 0);

    // Reset between arm and press: outputs clear at once, no ballot survives.
    snap();
    arm_pulse();
    step(1);
    chk("t6_armed", ready, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_ready_async", ready, 0);
    chk("t6_count_async", ballots_cast, 0);
    step(1);
    reset = 1'b1;
    btn_a = 1'b1;
    step(6);
    chk("t6_no_vote", cnt_va - base_va, 0);
    chk("t6_ready_idle", ready, 0);
    btn_a = 1'b0;
    step(3);

    // 256 accepted ballots wrap the counter back to 0.
    snap();
    for (int i = 0; i < 256; i++) begin
      arm_pulse();
      btn_a = 1'b1;
      step(4);
      btn_a = 1'b0;
      step(3);
      if (i == 254) chk("t5_count_255", ballots_cast, 255);
    end
    chk("t5_wrap", ballots_cast, 0);
    chk("t5_pulses", cnt_va - base_va, 256);
    chk("t5_never_both", cnt_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
